// File: rtl/count_display_if.sv
// Display-side bus of count_display: counter value and enable in,
// multiplexed seven-segment drive out (all outputs active-low).
interface count_display_if;
  logic [3:0] count;
  logic       enable;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  modport master (output count, output enable, input an, input seg, input dp);
  modport slave  (input count, input enable, output an, output seg, output dp);
endinterface

// File: rtl/count_display.sv
// Multiplexed 4-digit common-anode display for a 4-bit down-counter.
// D1:D0 decimal (leading zero blanked), D2 hex, D3 blank; the D0 decimal
// point flags a 15<-0 wrap for WRAP_FRAMES frames. The value is sampled
// once per frame so a frame never mixes two values.
module count_display #(
  parameter int SCAN_CYCLES = 50000,
  parameter int WRAP_FRAMES = 8
) (
  input  logic            mainClock,
  input  logic            reset,
  count_display_if.slave  bus
);

  localparam int RCW = $clog2(SCAN_CYCLES);
  localparam logic [RCW-1:0] RC_MAX = RCW'(SCAN_CYCLES - 1);
  localparam logic [7:0]     WRAP_LD = 8'(WRAP_FRAMES);
  localparam logic [6:0]     BLANK = 7'b1111111;

  typedef enum logic [1:0] {D0, D1, D2, D3} digit_e;

  logic [RCW-1:0] rc_q, rc_d;
  digit_e         di_q, di_d;
  logic [3:0]     sync1_q, sync1_d, sync2_q, sync2_d;
  logic [3:0]     shown_q, shown_d;
  logic [7:0]     wtimer_q, wtimer_d;
  logic [3:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;
  logic           dp_q, dp_d;

  logic           digit_tick, frame_tick;
  logic [3:0]     dig;
  logic           dig_blank;

  function automatic logic [6:0] seg_code(input logic [3:0] v);
    case (v)
      4'h0: seg_code = 7'b1000000;
      4'h1: seg_code = 7'b1111001;
      4'h2: seg_code = 7'b0100100;
      4'h3: seg_code = 7'b0110000;
      4'h4: seg_code = 7'b0011001;
      4'h5: seg_code = 7'b0010010;
      4'h6: seg_code = 7'b0000010;
      4'h7: seg_code = 7'b1111000;
      4'h8: seg_code = 7'b0000000;
      4'h9: seg_code = 7'b0010000;
      4'hA: seg_code = 7'b0001000;
      4'hB: seg_code = 7'b0000011;
      4'hC: seg_code = 7'b1000110;
      4'hD: seg_code = 7'b0100001;
      4'hE: seg_code = 7'b0000110;
      default: seg_code = 7'b0001110;
    endcase
  endfunction

  // Next-state: synchronizer, scan timing, frame snapshot/wrap timer, output drive
  always_comb begin
    sync1_d    = bus.count;
    sync2_d    = sync1_q;
    digit_tick = (rc_q == RC_MAX);
    frame_tick = digit_tick && (di_q == D3);
    rc_d       = digit_tick ? '0 : rc_q + 1'b1;

    di_d = di_q;
    if (digit_tick) begin
      case (di_q)
        D0:      di_d = D1;
        D1:      di_d = D2;
        D2:      di_d = D3;
        default: di_d = D0;
      endcase
    end

    shown_d  = shown_q;
    wtimer_d = wtimer_q;
    if (frame_tick) begin
      shown_d = sync2_q;
      // Down-counter wrap seen between two snapshots; reload beats decrement
      if (shown_q == 4'd0 && sync2_q == 4'd15) wtimer_d = WRAP_LD;
      else if (wtimer_q != 8'd0)               wtimer_d = wtimer_q - 8'd1;
    end

    dig       = shown_q;
    dig_blank = 1'b0;
    case (di_q)
      D0:      dig = (shown_q >= 4'd10) ? shown_q - 4'd10 : shown_q;
      D1:      begin dig = 4'd1; dig_blank = (shown_q < 4'd10); end
      D2:      dig = shown_q;
      default: dig_blank = 1'b1;
    endcase

    an_d  = bus.enable ? ~(4'b0001 << di_q) : 4'b1111;
    seg_d = (!bus.enable || dig_blank) ? BLANK : seg_code(dig);
    dp_d  = !(bus.enable && di_q == D0 && wtimer_q != 8'd0);
  end

  // State and registered outputs; reset aborts any frame in progress
  always_ff @(posedge mainClock or negedge reset) begin
    if (!reset) begin
      rc_q     <= '0;
      di_q     <= D0;
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      shown_q  <= 4'd0;
      wtimer_q <= 8'd0;
      an_q     <= 4'b1111;
      seg_q    <= BLANK;
      dp_q     <= 1'b1;
    end else begin
      rc_q     <= rc_d;
      di_q     <= di_d;
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      shown_q  <= shown_d;
      wtimer_q <= wtimer_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
    end
  end

  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;

endmodule

// File: tb/tb_count_display.sv
// Directed bench for count_display with SCAN_CYCLES=4 (16-cycle frames)
// and WRAP_FRAMES=3. e counts rising edges since the last reset release;
// frame f occupies output cycles 16f+1..16f+16 with D0,D1,D2,D3 slots of 4.
module tb_count_display;
  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S5 = 7'b0010010, S9 = 7'b0010000,
                         SC = 7'b1000110, SF = 7'b0001110, SB = 7'b1111111;
  localparam logic [3:0] A0 = 4'b1110, A1 = 4'b1101, A2 = 4'b1011,
                         A3 = 4'b0111, AX = 4'b1111;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   e = 0;
  int   n_pass = 0;
  int   n_total = 0;

  count_display_if bus_if ();

  count_display #(.SCAN_CYCLES(4), .WRAP_FRAMES(3)) dut (
    .mainClock (clk),
    .reset     (rst_n),
    .bus       (bus_if.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
    e = e + 1;
  endtask

  task automatic run_to(input int n);
    while (e < n) cyc();
  endtask

  task automatic chk(input string tag, input logic [3:0] ea,
                     input logic [6:0] es, input logic ed);
    n_total++;
    assert ({bus_if.an, bus_if.seg, bus_if.dp} === {ea, es, ed}) n_pass++;
    else $error("FAIL %s (e=%0d): an=%b seg=%b dp=%b, expected an=%b seg=%b dp=%b",
                tag, e, bus_if.an, bus_if.seg, bus_if.dp, ea, es, ed);
  endtask

  initial begin
    logic [3:0] an_tab [4];
    logic [6:0] seg_tab [4];
    an_tab  = '{A0, A1, A2, A3};
    seg_tab = '{S0, SB, S0, SB};
    bus_if.count  = 4'd0;
    bus_if.enable = 1'b1;

    // Reset state
    @(posedge clk); #2;
    chk("reset", AX, SB, 1'b1);
    @(posedge clk); #3;
    rst_n = 1'b1;
    e = 0;

    // Scan sequence: each digit held 4 cycles, count=0
    cyc();
    chk("first_edge", A0, S0, 1'b1);
    for (int d = 0; d < 4; d++) begin
      run_to(4*d + 1); chk("scan_start", an_tab[d], seg_tab[d], 1'b1);
      run_to(4*d + 4); chk("scan_end",   an_tab[d], seg_tab[d], 1'b1);
    end

    // Decimal/hex split: 12, then 5
    bus_if.count = 4'd12;
    run_to(33); chk("dec12_d0", A0, S2, 1'b1);
    run_to(37); chk("dec12_d1", A1, S1, 1'b1);
    run_to(41); chk("hex12_d2", A2, SC, 1'b1);
    run_to(44); bus_if.count = 4'd5;
    run_to(45); chk("d3_blank", A3, SB, 1'b1);
    run_to(49); chk("dec5_d0", A0, S5, 1'b1);
    run_to(53); chk("dec5_d1", A1, SB, 1'b1);
    run_to(57); chk("hex5_d2", A2, S5, 1'b1);

    // No tearing: 3 snapshotted, changes to 9 mid-frame
    bus_if.count = 4'd3;
    run_to(66); bus_if.count = 4'd9;
    run_to(67); chk("tear_d0", A0, S3, 1'b1);
    run_to(69); chk("tear_d1", A1, SB, 1'b1);
    run_to(73); chk("tear_d2", A2, S3, 1'b1);
    run_to(81); chk("next9_d0", A0, S9, 1'b1);
    run_to(85); chk("next9_d1", A1, SB, 1'b1);
    run_to(89); chk("next9_d2", A2, S9, 1'b1);

    // Wrap indicator: 0 shown in frame 6, 15 detected at edge 112
    bus_if.count = 4'd0;
    run_to(97); bus_if.count = 4'd15;
    run_to(112); chk("pre_wrap", A3, SB, 1'b1);
    run_to(113); chk("wrap_f1_d0", A0, S5, 1'b0);
    run_to(117); chk("wrap_f1_d1", A1, S1, 1'b1);
    run_to(121); chk("wrap_f1_d2", A2, SF, 1'b1);
    run_to(129); chk("wrap_f2_d0", A0, S5, 1'b0);
    // Shown 0 in frame 9 then 15 again: reload while still lit
    bus_if.count = 4'd0;
    run_to(145); chk("wrap_f3_d0", A0, S0, 1'b0);
    bus_if.count = 4'd15;
    run_to(148); chk("wrap_f3_d0end", A0, S0, 1'b0);
    run_to(149); chk("wrap_f3_d1", A1, SB, 1'b1);
    run_to(161); chk("rewrap_f1", A0, S5, 1'b0);
    run_to(177); chk("rewrap_f2", A0, S5, 1'b0);
    run_to(193); chk("rewrap_f3", A0, S5, 1'b0);
    run_to(209); chk("rewrap_off", A0, S5, 1'b1);

    // Enable low for 10 cycles mid-D1 of frame 13
    run_to(214); bus_if.enable = 1'b0;
    run_to(215); chk("dis_first", AX, SB, 1'b1);
    run_to(220); chk("dis_mid", AX, SB, 1'b1);
    run_to(224); chk("dis_last", AX, SB, 1'b1);
    bus_if.enable = 1'b1;
    run_to(225); chk("reen_d0", A0, S5, 1'b1);
    run_to(229); chk("reen_d1", A1, S1, 1'b1);

    // Async reset mid-D2 with the indicator lit
    bus_if.count = 4'd0;
    run_to(241); bus_if.count = 4'd15;
    run_to(257); chk("lit_before_rst", A0, S5, 1'b0);
    run_to(266); chk("d2_before_rst", A2, SF, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst", AX, SB, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_held", AX, SB, 1'b1);
    #2;
    rst_n = 1'b1;
    e = 0;
    cyc(); chk("post_rst_d0", A0, S0, 1'b1);
    run_to(5); chk("post_rst_d1", A1, SB, 1'b1);
    // count stayed 15, so the first frame tick sees a fresh 0->15 wrap
    run_to(17); chk("post_rst_wrap", A0, S5, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
